// File: rtl/mix_columns_stream.sv
// Streaming AES (Inv)MixColumns: gathers one 4-byte column from 1/2/4-byte beats,
// transforms it in the chosen direction and presents it through a one-deep output register.
module mix_columns_stream #(
  parameter int IN_BYTES = 1,
  parameter int NB       = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*IN_BYTES-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_col,
  output logic                  out_mode,
  output logic                  out_last
);

  localparam int BPC = 4 / IN_BYTES;
  localparam int W   = 8 * IN_BYTES;
  localparam int IW  = (NB > 1) ? $clog2(NB) : 1;

  generate
    if (!(IN_BYTES == 1 || IN_BYTES == 2 || IN_BYTES == 4)) begin : g_bad_in_bytes
      $error("mix_columns_stream: IN_BYTES must be 1, 2 or 4");
    end
    if (NB < 1 || NB > 8) begin : g_bad_nb
      $error("mix_columns_stream: NB must be in 1..8");
    end
  endgenerate

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] mul9(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] mul11(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] mul13(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] mul14(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

  // Row i lives in bits [31-8i -: 8]; the 2-bit row index wraps mod 4 for free.
  function automatic logic [31:0] mix_col(input logic [31:0] a, input logic inv);
    logic [7:0]  r [4];
    logic [31:0] res;
    logic [1:0]  j;
    res = 32'h0000_0000;
    for (int i = 0; i < 4; i++) begin
      r[i] = a[31-8*i -: 8];
    end
    for (int i = 0; i < 4; i++) begin
      j = 2'(i);
      if (inv) begin
        res[31-8*i -: 8] = mul14(r[j]) ^ mul11(r[j+2'd1]) ^ mul13(r[j+2'd2]) ^ mul9(r[j+2'd3]);
      end else begin
        res[31-8*i -: 8] = xtime(r[j]) ^ mul3(r[j+2'd1]) ^ r[j+2'd2] ^ r[j+2'd3];
      end
    end
    return res;
  endfunction

  state_t        state_r;
  state_t        state_next_s;
  logic [1:0]    beat_r;
  logic [31:0]   buf_r;
  logic          mode_r;
  logic [IW-1:0] idx_r;

  logic          accept_s;
  logic          last_beat_s;
  logic          out_free_s;
  logic          load_s;
  logic [31:0]   lane_mask_s;
  logic [31:0]   lane_data_s;
  logic [31:0]   col_s;
  logic          col_mode_s;
  logic [31:0]   result_s;

  assign accept_s    = in_valid && in_ready;
  assign last_beat_s = (beat_r == 2'(BPC - 1));
  assign out_free_s  = !out_valid || out_ready;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= FILL;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      FILL: begin
        if (accept_s && last_beat_s && !out_free_s) begin
          state_next_s = HOLD;
        end else begin
          state_next_s = FILL;
        end
      end
      HOLD: begin
        if (out_free_s) begin
          state_next_s = FILL;
        end else begin
          state_next_s = HOLD;
        end
      end
      default: state_next_s = FILL;
    endcase
  end

  // FSM outputs: HOLD refuses input, including on the cycle it drains.
  always_comb begin
    in_ready = 1'b0;
    load_s   = 1'b0;
    case (state_r)
      FILL: begin
        in_ready = 1'b1;
        load_s   = accept_s && last_beat_s && out_free_s;
      end
      HOLD: begin
        in_ready = 1'b0;
        load_s   = out_free_s;
      end
      default: begin
        in_ready = 1'b0;
        load_s   = 1'b0;
      end
    endcase
  end

  // Merge the incoming beat so the final beat can be transformed the same cycle.
  always_comb begin
    lane_mask_s = (~(32'hFFFF_FFFF >> W)) >> (W * int'(beat_r));
    lane_data_s = (32'(in_data) << (32 - W)) >> (W * int'(beat_r));
    if (accept_s) begin
      col_s = (buf_r & ~lane_mask_s) | (lane_data_s & lane_mask_s);
    end else begin
      col_s = buf_r;
    end
    if (accept_s && (beat_r == 2'd0)) begin
      col_mode_s = mode;
    end else begin
      col_mode_s = mode_r;
    end
    result_s = mix_col(col_s, col_mode_s);
  end

  // Accumulation buffer, beat counter and per-column mode
  always_ff @(posedge clock) begin
    if (reset) begin
      beat_r <= 2'd0;
      buf_r  <= 32'h0000_0000;
      mode_r <= 1'b0;
    end else if (accept_s) begin
      beat_r <= last_beat_s ? 2'd0 : beat_r + 2'd1;
      buf_r  <= col_s;
      mode_r <= col_mode_s;
    end
  end

  // Output register and column index; a load overrides the handshake clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_col   <= 32'h0000_0000;
      out_mode  <= 1'b0;
      out_last  <= 1'b0;
      idx_r     <= {IW{1'b0}};
    end else if (load_s) begin
      out_valid <= 1'b1;
      out_col   <= result_s;
      out_mode  <= col_mode_s;
      out_last  <= (idx_r == IW'(NB - 1));
      idx_r     <= (idx_r == IW'(NB - 1)) ? {IW{1'b0}} : idx_r + IW'(1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mix_columns_stream.sv
// Scoreboard bench for mix_columns_stream: three instances (1, 2 and 4 bytes per beat)
// checked against an independent shift-and-add GF(2^8) reference.
module tb_mix_columns_stream;

  localparam int NB = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset;

  logic        c1_mode, c1_in_valid, c1_in_ready, c1_out_valid, c1_out_ready, c1_out_mode, c1_out_last;
  logic [7:0]  c1_in_data;
  logic [31:0] c1_out_col;
  logic        c2_mode, c2_in_valid, c2_in_ready, c2_out_valid, c2_out_ready, c2_out_mode, c2_out_last;
  logic [15:0] c2_in_data;
  logic [31:0] c2_out_col;
  logic        c4_mode, c4_in_valid, c4_in_ready, c4_out_valid, c4_out_ready, c4_out_mode, c4_out_last;
  logic [31:0] c4_in_data;
  logic [31:0] c4_out_col;

  mix_columns_stream #(.IN_BYTES(1), .NB(NB)) u_dut1 (
    .clock(clock), .reset(reset), .mode(c1_mode), .in_valid(c1_in_valid), .in_ready(c1_in_ready),
    .in_data(c1_in_data), .out_valid(c1_out_valid), .out_ready(c1_out_ready), .out_col(c1_out_col),
    .out_mode(c1_out_mode), .out_last(c1_out_last));
  mix_columns_stream #(.IN_BYTES(2), .NB(NB)) u_dut2 (
    .clock(clock), .reset(reset), .mode(c2_mode), .in_valid(c2_in_valid), .in_ready(c2_in_ready),
    .in_data(c2_in_data), .out_valid(c2_out_valid), .out_ready(c2_out_ready), .out_col(c2_out_col),
    .out_mode(c2_out_mode), .out_last(c2_out_last));
  mix_columns_stream #(.IN_BYTES(4), .NB(NB)) u_dut4 (
    .clock(clock), .reset(reset), .mode(c4_mode), .in_valid(c4_in_valid), .in_ready(c4_in_ready),
    .in_data(c4_in_data), .out_valid(c4_out_valid), .out_ready(c4_out_ready), .out_col(c4_out_col),
    .out_mode(c4_out_mode), .out_last(c4_out_last));

  int tests_run = 0;
  int tests_failed = 0;
  // Entries are {mode, last, column}.
  logic [33:0] q1[$];
  logic [33:0] q2[$];
  logic [33:0] q4[$];
  int idx1, idx2, idx4;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [31:0] mix_model(input logic [31:0] col, input logic inv);
    logic [7:0]  c [4];
    logic [7:0]  a [4];
    logic [7:0]  acc;
    logic [31:0] res = 32'h0;
    if (inv) c = '{8'd14, 8'd11, 8'd13, 8'd9};
    else     c = '{8'd2, 8'd3, 8'd1, 8'd1};
    for (int i = 0; i < 4; i++) a[i] = col[31-8*i -: 8];
    for (int i = 0; i < 4; i++) begin
      acc = 8'h00;
      for (int j = 0; j < 4; j++) acc = acc ^ gmul(a[(i+j)%4], c[j]);
      res[31-8*i -: 8] = acc;
    end
    return res;
  endfunction

  task automatic push1(input logic [31:0] col, input logic m);
    q1.push_back({m, idx1 == NB-1, col});
    idx1 = (idx1 + 1) % NB;
  endtask

  task automatic push2(input logic [31:0] col, input logic m);
    q2.push_back({m, idx2 == NB-1, col});
    idx2 = (idx2 + 1) % NB;
  endtask

  task automatic push4(input logic [31:0] col, input logic m);
    q4.push_back({m, idx4 == NB-1, col});
    idx4 = (idx4 + 1) % NB;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    c1_in_valid = 1'b0; c2_in_valid = 1'b0; c4_in_valid = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    idx1 = 0; idx2 = 0; idx4 = 0;
    q1.delete(); q2.delete(); q4.delete();
  endtask

  // Drives one column byte-serially on the 1-byte instance; flip inverts mode after byte 0.
  task automatic drive1(input logic [31:0] col, input logic m, input logic flip, output int early);
    int g;
    early = 0;
    for (int k = 0; k < 4; k++) begin
      c1_in_valid = 1'b1;
      c1_in_data  = col[31-8*k -: 8];
      c1_mode     = (flip && k > 0) ? ~m : m;
      if (c1_out_valid) early++;
      g = 0;
      while (c1_in_ready !== 1'b1 && g < 100) begin
        @(negedge clock);
        g++;
      end
      if (g >= 100) begin
        tests_run++; tests_failed++;
        $display("FAIL drive1_ready: in_ready=%b required 1", c1_in_ready);
      end
      @(negedge clock);
    end
    c1_in_valid = 1'b0;
    c1_mode     = 1'b0;
  endtask

  task automatic test_reset();
    c1_out_ready = 1'b1; c2_out_ready = 1'b1; c4_out_ready = 1'b1;
    c1_mode = 1'b0; c2_mode = 1'b0; c4_mode = 1'b0;
    c1_in_data = 8'h00; c2_in_data = 16'h0000; c4_in_data = 32'h0;
    do_reset();
    tests_run++;
    if ({c1_out_valid, c1_out_mode, c1_out_last, c1_out_col, c1_in_ready} !== {3'b000, 32'h0, 1'b1}) begin
      tests_failed++;
      $display("FAIL reset_dut1: got v=%b m=%b l=%b col=%h rdy=%b required 0 0 0 00000000 1",
               c1_out_valid, c1_out_mode, c1_out_last, c1_out_col, c1_in_ready);
    end
    tests_run++;
    if ({c2_out_valid, c2_out_mode, c2_out_last, c2_out_col, c2_in_ready} !== {3'b000, 32'h0, 1'b1}) begin
      tests_failed++;
      $display("FAIL reset_dut2: got v=%b m=%b l=%b col=%h rdy=%b required 0 0 0 00000000 1",
               c2_out_valid, c2_out_mode, c2_out_last, c2_out_col, c2_in_ready);
    end
    tests_run++;
    if ({c4_out_valid, c4_out_mode, c4_out_last, c4_out_col, c4_in_ready} !== {3'b000, 32'h0, 1'b1}) begin
      tests_failed++;
      $display("FAIL reset_dut4: got v=%b m=%b l=%b col=%h rdy=%b required 0 0 0 00000000 1",
               c4_out_valid, c4_out_mode, c4_out_last, c4_out_col, c4_in_ready);
    end
  endtask

  task automatic test_forward_byte();
    logic [33:0] want;
    int early;
    c1_out_ready = 1'b1;
    push1(32'h8e4da1bc, 1'b0);
    drive1(32'hdb135345, 1'b0, 1'b0, early);
    tests_run++;
    if (early !== 0) begin
      tests_failed++;
      $display("FAIL fwd_early_valid: out_valid seen %0d times before final byte, required 0", early);
    end
    want = q1.pop_front();
    tests_run++;
    if (c1_out_valid !== 1'b1 || {c1_out_mode, c1_out_last, c1_out_col} !== want) begin
      tests_failed++;
      $display("FAIL fwd_col: got v=%b %h required v=1 %h", c1_out_valid,
               {c1_out_mode, c1_out_last, c1_out_col}, want);
    end
    @(negedge clock);
    tests_run++;
    if (c1_out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL fwd_one_cycle: out_valid=%b required 0", c1_out_valid);
    end
  endtask

  task automatic test_inverse_modes();
    logic [31:0] ins  [4] = '{32'h8e4da1bc, 32'hf20a225c, 32'h01010101, 32'h8e4da1bc};
    logic [31:0] exps [4] = '{32'hdb135345, 32'h9fdc589d, 32'h01010101, 32'hdb135345};
    logic        modes[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic        flips[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [33:0] want;
    int early;
    c1_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push1(exps[i], modes[i]);
      drive1(ins[i], modes[i], flips[i], early);
      want = q1.pop_front();
      tests_run++;
      if (c1_out_valid !== 1'b1 || {c1_out_mode, c1_out_last, c1_out_col} !== want) begin
        tests_failed++;
        $display("FAIL modes_col%0d: got v=%b %h required v=1 %h", i, c1_out_valid,
                 {c1_out_mode, c1_out_last, c1_out_col}, want);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_random_columns();
    logic [31:0] col;
    logic        m;
    logic [33:0] want;
    int early;
    c1_out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      col = $urandom;
      m   = 1'($urandom_range(0, 1));
      push1(mix_model(col, m), m);
      drive1(col, m, 1'b0, early);
      want = q1.pop_front();
      tests_run++;
      if (c1_out_valid !== 1'b1 || {c1_out_mode, c1_out_last, c1_out_col} !== want) begin
        tests_failed++;
        $display("FAIL random_col%0d: in %h mode %b got v=%b %h required v=1 %h", i, col, m,
                 c1_out_valid, {c1_out_mode, c1_out_last, c1_out_col}, want);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins  [5] = '{32'hc6c6c6c6, 32'hd4d4d4d5, 32'h2d26314c, 32'hdb135345, 32'h01020304};
    logic [31:0] exps [5] = '{32'hc6c6c6c6, 32'hd5d5d7d6, 32'h4d7ebdf8, 32'h8e4da1bc, 32'h0};
    logic [33:0] want;
    exps[4] = mix_model(ins[4], 1'b0);
    c4_out_ready = 1'b1;
    for (int i = 0; i <= 5; i++) begin
      if (i > 0) begin
        want = q4.pop_front();
        tests_run++;
        if (c4_out_valid !== 1'b1 || {c4_out_mode, c4_out_last, c4_out_col} !== want) begin
          tests_failed++;
          $display("FAIL b2b_col%0d: got v=%b %h required v=1 %h", i-1, c4_out_valid,
                   {c4_out_mode, c4_out_last, c4_out_col}, want);
        end
      end
      if (i < 5) begin
        tests_run++;
        if (c4_in_ready !== 1'b1) begin
          tests_failed++;
          $display("FAIL b2b_ready%0d: in_ready=%b required 1", i, c4_in_ready);
        end
        c4_in_valid = 1'b1; c4_in_data = ins[i]; c4_mode = 1'b0;
        push4(exps[i], 1'b0);
      end else begin
        c4_in_valid = 1'b0;
      end
      @(negedge clock);
    end
    tests_run++;
    if (c4_out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_drain: out_valid=%b required 0", c4_out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [33:0] want;
    c4_out_ready = 1'b0;
    c4_mode = 1'b0;
    c4_in_valid = 1'b1; c4_in_data = 32'hdb135345; push4(32'h8e4da1bc, 1'b0);
    @(negedge clock);
    c4_in_data = 32'hf20a225c; push4(32'h9fdc589d, 1'b0);
    @(negedge clock);
    c4_in_data = 32'h01010101;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (c4_in_ready !== 1'b0 || c4_out_valid !== 1'b1 ||
          {c4_out_mode, c4_out_last, c4_out_col} !== q4[0]) begin
        tests_failed++;
        $display("FAIL bp_hold%0d: rdy=%b v=%b out %h required rdy=0 v=1 %h", i, c4_in_ready,
                 c4_out_valid, {c4_out_mode, c4_out_last, c4_out_col}, q4[0]);
      end
      @(negedge clock);
    end
    c4_in_valid = 1'b0;
    c4_out_ready = 1'b1;
    @(negedge clock);
    c4_out_ready = 1'b0;
    void'(q4.pop_front());
    want = q4[0];
    tests_run++;
    if (c4_out_valid !== 1'b1 || c4_in_ready !== 1'b1 || {c4_out_mode, c4_out_last, c4_out_col} !== want) begin
      tests_failed++;
      $display("FAIL bp_release: v=%b rdy=%b out %h required v=1 rdy=1 %h", c4_out_valid,
               c4_in_ready, {c4_out_mode, c4_out_last, c4_out_col}, want);
    end
    c4_out_ready = 1'b1;
    @(negedge clock);
    void'(q4.pop_front());
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (c4_out_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_no_dup%0d: out_valid=%b required 0", i, c4_out_valid);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_reset_partial();
    logic [33:0] want;
    logic [15:0] beats [2] = '{16'hdb13, 16'h5345};
    int g;
    c2_out_ready = 1'b1;
    c2_mode = 1'b0;
    c2_in_valid = 1'b1; c2_in_data = 16'hdb13;
    @(negedge clock);
    c2_in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    tests_run++;
    if (c2_out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstp_in_reset: out_valid=%b required 0", c2_out_valid);
    end
    reset = 1'b0;
    idx1 = 0; idx2 = 0; idx4 = 0;
    q1.delete(); q2.delete(); q4.delete();
    push2(32'h8e4da1bc, 1'b0);
    for (int k = 0; k < 2; k++) begin
      c2_in_valid = 1'b1; c2_in_data = beats[k];
      g = 0;
      while (c2_in_ready !== 1'b1 && g < 100) begin
        @(negedge clock);
        g++;
      end
      if (g >= 100) begin
        tests_run++; tests_failed++;
        $display("FAIL rstp_ready: in_ready=%b required 1", c2_in_ready);
      end
      tests_run++;
      if (c2_out_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL rstp_spurious%0d: out_valid=%b required 0", k, c2_out_valid);
      end
      @(negedge clock);
    end
    c2_in_valid = 1'b0;
    want = q2.pop_front();
    tests_run++;
    if (c2_out_valid !== 1'b1 || {c2_out_mode, c2_out_last, c2_out_col} !== want) begin
      tests_failed++;
      $display("FAIL rstp_col: got v=%b %h required v=1 %h", c2_out_valid,
               {c2_out_mode, c2_out_last, c2_out_col}, want);
    end
    @(negedge clock);
    tests_run++;
    if (c2_out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstp_after: out_valid=%b required 0", c2_out_valid);
    end
  endtask

  task automatic test_reset_hold();
    logic [31:0] col;
    logic [33:0] want;
    c4_out_ready = 1'b0;
    c4_mode = 1'b0;
    c4_in_valid = 1'b1; c4_in_data = 32'hdb135345;
    @(negedge clock);
    c4_in_data = 32'hf20a225c;
    @(negedge clock);
    c4_in_valid = 1'b0;
    tests_run++;
    if (c4_in_ready !== 1'b0 || c4_out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL rsth_parked: rdy=%b v=%b required rdy=0 v=1", c4_in_ready, c4_out_valid);
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    idx1 = 0; idx2 = 0; idx4 = 0;
    q1.delete(); q2.delete(); q4.delete();
    tests_run++;
    if (c4_out_valid !== 1'b0 || c4_in_ready !== 1'b1 || c4_out_col !== 32'h0) begin
      tests_failed++;
      $display("FAIL rsth_cleared: v=%b rdy=%b col=%h required v=0 rdy=1 col=00000000",
               c4_out_valid, c4_in_ready, c4_out_col);
    end
    c4_out_ready = 1'b1;
    for (int i = 0; i <= 4; i++) begin
      if (i > 0) begin
        want = q4.pop_front();
        tests_run++;
        if (c4_out_valid !== 1'b1 || {c4_out_mode, c4_out_last, c4_out_col} !== want) begin
          tests_failed++;
          $display("FAIL rsth_col%0d: got v=%b %h required v=1 %h", i-1, c4_out_valid,
                   {c4_out_mode, c4_out_last, c4_out_col}, want);
        end
      end
      if (i < 4) begin
        col = $urandom;
        c4_in_valid = 1'b1; c4_in_data = col; c4_mode = 1'b1;
        push4(mix_model(col, 1'b1), 1'b1);
      end else begin
        c4_in_valid = 1'b0;
      end
      @(negedge clock);
    end
    tests_run++;
    if (c4_out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rsth_drain: out_valid=%b required 0", c4_out_valid);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    c1_in_valid = 1'b0; c2_in_valid = 1'b0; c4_in_valid = 1'b0;
    test_reset();
    test_forward_byte();
    test_inverse_modes();
    test_random_columns();
    test_back_to_back();
    test_backpressure();
    test_reset_partial();
    test_reset_hold();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
